// File: rtl/rmst_mem_responder_if.sv
// rmst read-master bundle between a tile loader (master) and the memory-side
// responder (slave).
//   command : rmst_fixed_location, rmst_read_base, rmst_read_length, rmst_go
//   status  : rmst_done (one-cycle completion pulse)
//   stream  : rmst_user_read_buffer (pop), rmst_user_buffer_data (show-ahead
//             head), rmst_user_data_available (FIFO non-empty)
interface rmst_mem_responder_if #(
    parameter int XAW = 32,
    parameter int XDW = 128
);
    logic           rmst_fixed_location;
    logic [XAW-1:0] rmst_read_base;
    logic [XAW-1:0] rmst_read_length;
    logic           rmst_go;
    logic           rmst_done;
    logic           rmst_user_read_buffer;
    logic [XDW-1:0] rmst_user_buffer_data;
    logic           rmst_user_data_available;

    modport master (
        output rmst_fixed_location, rmst_read_base, rmst_read_length, rmst_go,
        output rmst_user_read_buffer,
        input  rmst_done, rmst_user_buffer_data, rmst_user_data_available
    );

    modport slave (
        input  rmst_fixed_location, rmst_read_base, rmst_read_length, rmst_go,
        input  rmst_user_read_buffer,
        output rmst_done, rmst_user_buffer_data, rmst_user_data_available
    );
endinterface

// File: rtl/rmst_mem_responder.sv
// Memory-side responder for the rmst read-master protocol. A go command
// latches a word address/count, words are read from a preloadable internal
// memory (1-cycle latency) into a show-ahead FIFO, and done pulses once the
// last word has been popped by the user.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   rmst (slave)      : command, done pulse and user read stream
//   mem_wr_en/addr/data : preload write port, usable in any state
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for go; command inputs sampled only here
//   S_FETCH | issuing one memory read per cycle while FIFO space allows
//   S_DRAIN | all reads issued; wait for FIFO empty + no read in flight
module rmst_mem_responder #(
    parameter int XAW        = 32,
    parameter int XDW        = 128,
    parameter int BYTE_SHIFT = 4,
    parameter int MEM_AW     = 12,
    parameter int FIFO_AW    = 5
) (
    input  logic              clk,
    input  logic              rst,
    rmst_mem_responder_if.slave rmst,
    input  logic              mem_wr_en,
    input  logic [MEM_AW-1:0] mem_wr_addr,
    input  logic [XDW-1:0]    mem_wr_data
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int MEM_WORDS = 1 << MEM_AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_t;

    state_t              state_q;
    logic [MEM_AW-1:0]   addr_q;
    logic [XAW-1:0]      remain_q;
    logic                fixed_q;
    logic                inflight_q;
    logic                done_q;

    logic [XDW-1:0]      mem [MEM_WORDS];
    logic [XDW-1:0]      rd_data_q;

    logic [XDW-1:0]      fifo_mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q;
    logic [FIFO_AW-1:0]  rd_ptr_q;
    logic [FIFO_AW:0]    count_q;
    logic [FIFO_AW:0]    count_d;

    logic [XAW-1:0]      len_words;
    logic [MEM_AW-1:0]   base_word;
    logic                issue;
    logic                push;
    logic                pop;

    assign len_words = rmst.rmst_read_length >> BYTE_SHIFT;
    assign base_word = MEM_AW'(rmst.rmst_read_base >> BYTE_SHIFT);

    // An in-flight read already owns a FIFO slot, so it is counted against
    // the depth; this is what keeps the FIFO from ever overflowing.
    assign issue = (state_q == S_FETCH) && (remain_q != '0) &&
                   ((count_q + {{FIFO_AW{1'b0}}, inflight_q}) < (FIFO_AW+1)'(DEPTH));
    assign push  = inflight_q;
    assign pop   = rmst.rmst_user_read_buffer && (count_q != '0);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            fixed_q    <= 1'b0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue;
            case (state_q)
                S_IDLE: begin
                    if (rmst.rmst_go) begin
                        addr_q   <= base_word;
                        remain_q <= len_words;
                        fixed_q  <= rmst.rmst_fixed_location;
                        state_q  <= (len_words != '0) ? S_FETCH : S_DRAIN;
                    end
                end
                S_FETCH: begin
                    if (issue) begin
                        remain_q <= remain_q - XAW'(1);
                        if (!fixed_q) begin
                            addr_q <= addr_q + 1'b1;
                        end
                        if (remain_q == XAW'(1)) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if ((count_q == '0) && !inflight_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Memory contents survive reset. Non-blocking read gives old data when a
    // preload write hits the address being fetched in the same cycle.
    always_ff @(posedge clk) begin
        if (mem_wr_en) begin
            mem[mem_wr_addr] <= mem_wr_data;
        end
        if (issue) begin
            rd_data_q <= mem[addr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= rd_data_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign rmst.rmst_done                = done_q;
    assign rmst.rmst_user_buffer_data    = fifo_mem[rd_ptr_q];
    assign rmst.rmst_user_data_available = (count_q != '0);

endmodule

// File: doc/rmst_mem_responder.md
# rmst_mem_responder

Memory-side responder for the read-master (rmst) interface that tile loaders use to fetch in_fm, weight and out_fm data. It accepts a go/base/length command, streams XDW-wide words from an internal preloadable memory through a show-ahead FIFO to the user read port, and pulses done once every word has been consumed. It is the slave end of the rmst protocol and sits in the laptop simulation environment, one instance per rmst port of a conv tile.

## Interface
Parameters:
- XAW, 32, command address/length width (bytes)
- XDW, 128, data word width
- BYTE_SHIFT, 4, log2(XDW/8); byte-to-word shift
- MEM_AW, 12, word address width of internal memory (2^MEM_AW words)
- FIFO_AW, 5, log2 of FIFO depth (depth 32)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- rmst_fixed_location  in  1  1: every word read from the base address
- rmst_read_base  in  XAW  byte start address, sampled with go; low BYTE_SHIFT bits ignored
- rmst_read_length  in  XAW  byte count, sampled with go; low BYTE_SHIFT bits ignored
- rmst_go  in  1  command strobe, honoured only in IDLE
- rmst_done  out  1  one-cycle pulse: command complete
- rmst_user_read_buffer  in  1  pop FIFO head; ignored when empty
- rmst_user_buffer_data  out  XDW  FIFO head (show-ahead)
- rmst_user_data_available  out  1  FIFO non-empty
- mem_wr_en  in  1  preload write strobe
- mem_wr_addr  in  MEM_AW  preload word address
- mem_wr_data  in  XDW  preload data

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE: on go, latch addr = read_base >> BYTE_SHIFT (truncated to MEM_AW), remain = read_length >> BYTE_SHIFT, fixed = fixed_location. remain != 0 -> FETCH, else -> DRAIN.
- FETCH: issue one memory read per cycle when remain != 0 and fifo_count + inflight < 2^FIFO_AW. On issue: remain--, addr++ unless fixed. Issue that makes remain 0 -> DRAIN.
- Memory read latency 1 cycle; returned word pushed into FIFO on the next edge. inflight is 0 or 1.
- DRAIN: when FIFO empty and inflight == 0, drive done high for one cycle, return to IDLE.
- Address wraps modulo 2^MEM_AW; no error.
- go outside IDLE ignored; command inputs only sampled in IDLE.
- Pop with FIFO empty ignored. Simultaneous push and pop: count unchanged, both take effect.
- Preload write and fetch to same address in one cycle: read returns old data. Preload allowed in any state.
- Word order delivered equals issue order; no drop, no duplication.

## Timing
- Reset values: rmst_done 0, rmst_user_data_available 0, state IDLE, FIFO empty, remain/addr/inflight 0. rmst_user_buffer_data don't-care while available = 0. Memory contents not reset; preserved through rst.
- rst asserted mid-command: immediate abort, FIFO flushed, no done pulse; next go after release starts cleanly.
- go sampled at edge E0 -> first read issued at E1 -> pushed at E2 -> available = 1 after E2.
- Sustained throughput 1 word/cycle when user pops every cycle.
- Last pop at edge Ep (inflight 0) -> done = 1 during cycle Ep+1..Ep+2, 0 after; new go accepted from Ep+2.
- Zero-length go at E0 -> done = 1 after E1 for one cycle.
- FIFO full with no pops: issue stalls with remain held; resumes the cycle after a pop frees space; never overflows.

## Test plan
- Preload words 0..15 = i; go base 0x40, length 0x80, fixed 0, pop every cycle -> 8 words 4..11 in order, available after 2 cycles, single done 1 cycle after 8th pop.
- go length 0x1000 (256 words), no pops for 100 cycles -> fifo holds exactly 32, available stays 1, no overwrite; then pop all -> 256 words in order, one done.
- fixed_location 1, base 0x30, length 0x40 -> 4 copies of word 3.
- Zero length go -> done pulse after 1 cycle, available never 1; go while FETCH busy ignored (word count unchanged).
- base = (2^MEM_AW - 2) << 4, length 0x40 -> words 4094, 4095, 0, 1.
- rst pulse after 3 pops of an 8-word command -> available 0, no done; new 4-word go delivers correct 4 words and one done.
